// File: rtl/fir_xifu_id_tracker.sv
// Per-ID issue/commit/kill lifecycle tracker with outstanding limit.
// Optional sticky protocol-error flag: FIR_XIFU_ID_TRACKER_ERR_EN.
module fir_xifu_id_tracker #(
  parameter int unsigned X_ID_WIDTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2**X_ID_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       issue_valid_i,
  input  logic [X_ID_WIDTH-1:0]      issue_id_i,
  output logic                       issue_ready_o,
  input  logic                       commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]      commit_id_i,
  input  logic                       commit_kill_i,
  input  logic [2**X_ID_WIDTH-1:0]   clear_i,
  output logic [2**X_ID_WIDTH-1:0]   issued_o,
  output logic [2**X_ID_WIDTH-1:0]   committed_o,
  output logic [2**X_ID_WIDTH-1:0]   killed_o,
  output logic [X_ID_WIDTH:0]        outstanding_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       err_o
);

  localparam int unsigned X_ID_MAX = 2**X_ID_WIDTH;
  localparam logic [X_ID_WIDTH:0] MAX_CNT =
    (X_ID_WIDTH+1)'(MAX_OUTSTANDING);
  localparam logic [X_ID_WIDTH+1:0] MAX_W =
    (X_ID_WIDTH+2)'(MAX_OUTSTANDING);

  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > X_ID_MAX) begin : g_bad_cfg
    $error("MAX_OUTSTANDING out of range 1..2**X_ID_WIDTH");
  end

  typedef enum logic [1:0] {
    FREE      = 2'b00,
    ISSUED    = 2'b01,
    COMMITTED = 2'b10,
    KILLED    = 2'b11
  } id_state_e;

  id_state_e           st_q [X_ID_MAX];
  id_state_e           st_d [X_ID_MAX];
  logic [X_ID_WIDTH:0] cnt_q, cnt_d;
  logic [X_ID_WIDTH:0] n_clr;
  logic [X_ID_WIDTH+1:0] sum, diff;
  logic                accept;
  logic                commit_hit;
  logic                bad_commit, bad_clear;

  // Ready looks only at pre-update state, so a same-cycle clear never frees a slot
  assign full_o        = (cnt_q == MAX_CNT);
  assign empty_o       = (cnt_q == '0);
  assign outstanding_o = cnt_q;
  assign issue_ready_o = !full_o && (st_q[issue_id_i] == FREE);
  assign accept        = issue_valid_i && issue_ready_o;

  always_comb begin
    st_d       = st_q;
    n_clr      = '0;
    bad_commit = 1'b0;
    bad_clear  = 1'b0;
    commit_hit = 1'b0;
    for (int i = 0; i < X_ID_MAX; i++) begin
      commit_hit = commit_valid_i &&
                   (commit_id_i == X_ID_WIDTH'(i));
      unique case (st_q[i])
        FREE: begin
          if (accept && issue_id_i == X_ID_WIDTH'(i))
            st_d[i] = ISSUED;
          if (commit_hit) bad_commit = 1'b1;
          if (clear_i[i]) bad_clear = 1'b1;
        end
        ISSUED: begin
          if (commit_hit)
            st_d[i] = commit_kill_i ? KILLED : COMMITTED;
          if (clear_i[i]) bad_clear = 1'b1;
        end
        COMMITTED, KILLED: begin
          if (commit_hit) bad_commit = 1'b1;
          if (clear_i[i]) begin
            st_d[i] = FREE;
            n_clr   = n_clr + (X_ID_WIDTH+1)'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    sum  = {1'b0, cnt_q} + (X_ID_WIDTH+2)'(accept);
    diff = '0;
    if (sum < {1'b0, n_clr}) begin
      cnt_d = '0;
    end else begin
      diff  = sum - {1'b0, n_clr};
      cnt_d = (diff > MAX_W) ? MAX_CNT : diff[X_ID_WIDTH:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < X_ID_MAX; i++) st_q[i] <= FREE;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < X_ID_MAX; i++) st_q[i] <= st_d[i];
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < X_ID_MAX; i++) begin
      issued_o[i]    = (st_q[i] == ISSUED);
      committed_o[i] = (st_q[i] == COMMITTED);
      killed_o[i]    = (st_q[i] == KILLED);
    end
  end

`ifdef FIR_XIFU_ID_TRACKER_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_q | bad_commit | bad_clear;
  end

  assign err_o = err_q;
`else
  logic unused_err;
  assign unused_err = bad_commit | bad_clear;
  assign err_o      = 1'b0;
`endif

endmodule
